// File: rtl/cmd_framer.sv
// Initiator-side command framer.
// Frames one request as header {mode,cmd}, length LSB, length MSB, then
// either streams write payload from the local byte source or collects read
// response bytes from the inbound link, aborting if the gap between
// response bytes exceeds TIMEOUT_CYCLES.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | ready for a request, nothing on the link
// S_HDR     | header byte {mode,cmd} presented on tx
// S_LEN_LO  | length bits [7:0] presented on tx
// S_LEN_HI  | length bits [15:8] presented on tx
// S_WR_DATA | forwarding wr_data bytes to tx until len bytes transferred
// S_RD_DATA | collecting len response bytes from rx under a gap timeout
module cmd_framer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_usb,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_mode,
    input  logic [5:0]  req_cmd,
    input  logic [15:0] req_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] byte_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN_LO,
        S_LEN_HI,
        S_WR_DATA,
        S_RD_DATA
    } state_t;

    // Gap timer is a down-counter; reaching zero means TIMEOUT_CYCLES
    // cycles have elapsed since the last load.
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [15:0] r_len;
    logic [15:0] r_last_idx;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_tmo;
    logic [15:0] r_byte_index;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;
    logic        r_rd_last;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_tx_xfer;
    logic        w_wr_take;
    logic        w_last_byte;
    logic        w_wr_ready;

    // Handshake and terminal-index decode shared by the FSM.
    assign w_tx_xfer   = r_tx_valid && tx_ready;
    assign w_last_byte = (r_byte_index == r_last_idx);
    // Stop pulling source bytes once len bytes are accepted, even while the
    // final one is still waiting on the link.
    assign w_wr_ready  = (r_state == S_WR_DATA) && (r_wr_cnt != r_len) &&
                         (!r_tx_valid || tx_ready);
    assign w_wr_take   = wr_valid && w_wr_ready;

    assign req_ready  = (r_state == S_IDLE);
    assign wr_ready   = w_wr_ready;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign rd_last    = r_rd_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign byte_index = r_byte_index;

    // Framing FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk_usb or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 2'b00;
            r_len        <= 16'd0;
            r_last_idx   <= 16'd0;
            r_wr_cnt     <= 16'd0;
            r_tmo        <= 16'd0;
            r_byte_index <= 16'd0;
            r_tx_data    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_rd_data    <= 8'd0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mode       <= req_mode;
                        r_len        <= req_len;
                        r_last_idx   <= req_len - 16'd1;
                        r_wr_cnt     <= 16'd0;
                        r_byte_index <= 16'd0;
                        if (req_len == 16'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= S_HDR;
                            r_busy     <= 1'b1;
                            r_tx_data  <= {req_mode, req_cmd};
                            r_tx_valid <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_tx_xfer) begin
                        r_tx_data <= r_len[7:0];
                        r_state   <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_tx_xfer) begin
                        r_tx_data <= r_len[15:8];
                        r_state   <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_tx_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_tmo      <= TMO_LOAD;
                        case (r_mode)
                            2'b11:   r_state <= S_WR_DATA;
                            2'b10:   r_state <= S_RD_DATA;
                            default: begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WR_DATA: begin
                    // A take and the final transfer never coincide: the final
                    // transfer only happens once all len bytes were taken.
                    if (w_wr_take) begin
                        r_tx_data  <= wr_data;
                        r_tx_valid <= 1'b1;
                        r_wr_cnt   <= r_wr_cnt + 16'd1;
                    end else if (w_tx_xfer) begin
                        r_tx_valid <= 1'b0;
                    end
                    if (w_tx_xfer) begin
                        if (w_last_byte) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_byte_index <= r_byte_index + 16'd1;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (rx_valid) begin
                        r_rd_data  <= rx_data;
                        r_rd_valid <= 1'b1;
                        r_tmo      <= TMO_LOAD;
                        if (w_last_byte) begin
                            r_rd_last <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_byte_index <= r_byte_index + 16'd1;
                        end
                    end else if (r_tmo == 16'd0) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo - 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cmd_framer.md
Name: cmd_framer

Overview:
Initiator side of the serial command protocol. Takes one command request (mode, 6-bit command, 16-bit length) and frames it onto an outbound byte stream: header byte, length LSB, length MSB, then payload. Write-mode payload comes from a local byte source. Read-mode response bytes are collected from the inbound stream under a timeout. Sits between local control logic (or a test master) and the USB/serial TX/RX byte links, facing a target that decodes the same framing.

Parameters:
TIMEOUT_CYCLES, 65535, max clk_usb cycles allowed between read-response bytes before abort (1..65535)

Ports:
clk_usb  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command request valid
req_ready  out  1  framer idle, request accepted when req_valid && req_ready
req_mode  in  2  2'b10 read, 2'b11 write, others header-only
req_cmd  in  6  command code
req_len  in  16  payload byte count (1..65535)
wr_data  in  8  write-mode payload byte
wr_valid  in  1  wr_data valid
wr_ready  out  1  framer consumes wr_data when wr_valid && wr_ready
tx_data  out  8  outbound byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  link accepts byte when tx_valid && tx_ready
rx_data  in  8  inbound response byte
rx_valid  in  1  single-cycle strobe, rx_data valid
rd_data  out  8  read-mode response byte
rd_valid  out  1  single-cycle strobe with rd_data
rd_last  out  1  high with rd_valid on final response byte
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on reject or timeout
byte_index  out  16  index of current payload byte, 0-based

Behaviour:
- Reset (async, rst_n low): state IDLE. tx_valid, wr_ready, rd_valid, rd_last, done, err, busy = 0. tx_data, rd_data, byte_index = 0. req_ready = 1 after reset release. Reset mid-frame abandons the frame with no completion pulse.
- All outputs registered except req_ready (= state==IDLE) and wr_ready (combinational, defined below).
- IDLE: on req_valid, capture mode/cmd/len.
  - If req_len==0: pulse err next cycle, stay IDLE, transmit nothing.
  - Otherwise go to HDR with tx_data={req_mode,req_cmd} and tx_valid=1 on the next cycle.
- Output handshake: tx_data/tx_valid held stable until tx_ready. The byte transfers on the cycle tx_valid && tx_ready. No byte is dropped or duplicated.
- HDR -> LEN_LO (tx_data=len[7:0]) -> LEN_HI (tx_data=len[15:8]). Each advance happens on a transfer. Length is sent little-endian.
- After the LEN_HI transfer:
  - mode 11 -> WR_DATA.
  - mode 10 -> RD_DATA.
  - mode 00/01 -> IDLE with done pulse.
- WR_DATA:
  - wr_ready = !tx_valid || tx_ready.
  - On wr_valid && wr_ready: tx_data<=wr_data, tx_valid<=1, byte_index increments after each tx transfer.
  - Back-to-back bytes sustain 1 byte/cycle when tx_ready is held high.
  - After the len-th byte transfers: IDLE with done pulse and tx_valid=0. wr_ready stays 0 outside WR_DATA.
- RD_DATA:
  - tx_valid=0. Timeout counter cleared on entry and on each rx_valid.
  - Each rx_valid: rd_data<=rx_data, rd_valid pulse one cycle later, byte_index increments.
  - Byte len-1 also asserts rd_last; then IDLE with done in the same cycle as rd_last.
  - If the counter reaches TIMEOUT_CYCLES with no rx_valid: pulse err, return to IDLE, rd_last not asserted.
  - rx_valid outside RD_DATA is ignored.
- byte_index is 16 bits. It counts 0..len-1 and never wraps within a frame; len=65535 is legal. It is reset to 0 on accepting a request.
- A new request is accepted in the cycle after done/err (req_ready high again). req_valid while busy is not accepted.

Test Plan:
- Write frame: req mode=11 cmd=0x05 len=3, wr bytes A1 A2 A3, tx_ready=1 -> tx stream C5 03 00 A1 A2 A3, single done pulse, byte_index ends 2, wr_ready low after third byte.
- Backpressure: same frame with tx_ready toggling 1/0 each cycle and wr_valid gaps -> identical 6-byte stream. tx_data stable while tx_valid && !tx_ready.
- Read frame: mode=10 cmd=0x01 len=0x0102 -> tx 81 02 01. Feed 258 rx bytes with random gaps -> 258 rd_valid pulses in order, rd_last only on 258th, done coincident.
- Timeout: TIMEOUT_CYCLES=16, read len=4, supply 2 rx bytes then stop -> err pulse 16 cycles after last rx, no done, no rd_last, req_ready returns 1.
- Edge requests: len=0 -> err, zero tx bytes. Mode=00 cmd=0x3F len=1 -> tx 3F 01 00, then done, no payload phase.
- Reset mid-write after 2 payload bytes -> all outputs zero immediately (async). Next request frames correctly from header.
